branch_target_unit: RTL and testbench

- Parametrised, pipelined successor to the single-cycle branch target adder.
- Computes branch/jump targets with a selectable base (PC-relative or register-indirect).
- Resolves the branch condition and emits NextPC plus a misalignment flag.
- Sits between decode/execute and the fetch PC mux; two-stage valid/ready pipeline with flush.

---
 rtl/branch_target_unit.sv | 130 +++++++++++++
 tb/tb_branch_target_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_unit.sv
// Two-stage branch/jump target unit: resolves the condition and
// produces Target, NextPC, Taken and Misalign behind a valid/ready pipe.
module branch_target_unit #(
  parameter int WIDTH      = 32,
  parameter int OFF_WIDTH  = 16,
  parameter int SHIFT      = 2,
  parameter int INC        = 4,
  parameter int ALIGN_BITS = 2
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Flush,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [WIDTH-1:0]     PCIn,
  input  logic [WIDTH-1:0]     RegBase,
  input  logic [WIDTH-1:0]     OpA,
  input  logic [WIDTH-1:0]     OpB,
  input  logic [OFF_WIDTH-1:0] Offset,
  input  logic [2:0]           Mode,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [WIDTH-1:0]     Target,
  output logic [WIDTH-1:0]     NextPC,
  output logic                 Taken,
  output logic                 Misalign
);

  localparam logic [2:0] M_BEQ = 3'd0;
  localparam logic [2:0] M_BNE = 3'd1;
  localparam logic [2:0] M_BLT = 3'd2;
  localparam logic [2:0] M_BGE = 3'd3;
  localparam logic [2:0] M_JAL = 3'd4;
  localparam logic [2:0] M_JR  = 3'd5;

  logic             r_v1;
  logic             r_v2;
  logic [WIDTH-1:0] r_base;
  logic [WIDTH-1:0] r_extoff;
  logic [WIDTH-1:0] r_pcinc;
  logic             r_cond;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_nextpc;
  logic             r_taken;
  logic             r_mis;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_ld1;
  logic             w_ld2;
  logic             w_cond;
  logic [WIDTH-1:0] w_ext;
  logic [WIDTH-1:0] w_extoff;
  logic [WIDTH-1:0] w_target;
  logic             w_mis;

  assign w_s2_adv = ~r_v2 | Out_Ready;
  assign w_s1_adv = ~r_v1 | w_s2_adv;
  // Flush empties both stages, so the unit is always ready then
  assign In_Ready = w_s1_adv | Flush;
  assign w_ld1    = In_Valid & w_s1_adv & ~Flush;
  assign w_ld2    = r_v1 & w_s2_adv & ~Flush;

  assign w_ext    = {{(WIDTH-OFF_WIDTH){Offset[OFF_WIDTH-1]}}, Offset};
  assign w_extoff = w_ext << SHIFT;

  always_comb begin
    w_cond = 1'b0;
    unique case (1'b1)
      (Mode == M_BEQ): w_cond = (OpA == OpB);
      (Mode == M_BNE): w_cond = (OpA != OpB);
      (Mode == M_BLT): w_cond = ($signed(OpA) < $signed(OpB));
      (Mode == M_BGE): w_cond = ($signed(OpA) >= $signed(OpB));
      (Mode == M_JAL): w_cond = 1'b1;
      (Mode == M_JR):  w_cond = 1'b1;
      default:         w_cond = 1'b0;
    endcase
  end

  assign w_target = r_base + r_extoff;
  assign w_mis    = r_cond & (w_target[ALIGN_BITS-1:0] != '0);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else if (Flush) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      if (w_s2_adv) r_v2 <= r_v1;
      if (w_s1_adv) r_v1 <= In_Valid;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_base   <= '0;
      r_extoff <= '0;
      r_pcinc  <= '0;
      r_cond   <= 1'b0;
    end else if (w_ld1) begin
      r_base   <= (Mode == M_JR) ? RegBase : PCIn;
      r_extoff <= w_extoff;
      r_pcinc  <= PCIn + WIDTH'(INC);
      r_cond   <= w_cond;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_target <= '0;
      r_nextpc <= '0;
      r_taken  <= 1'b0;
      r_mis    <= 1'b0;
    end else if (w_ld2) begin
      r_target <= w_target;
      r_nextpc <= r_cond ? w_target : r_pcinc;
      r_taken  <= r_cond;
      r_mis    <= w_mis;
    end
  end

  assign Out_Valid = r_v2;
  assign Target    = r_target;
  assign NextPC    = r_nextpc;
  assign Taken     = r_taken;
  assign Misalign  = r_mis;

endmodule

// File: tb/tb_branch_target_unit.sv
// Scoreboard bench for branch_target_unit: directed scenarios plus
// randomized traffic with random backpressure and flushes.
module tb_branch_target_unit;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Flush = 1'b0;
  logic        In_Valid = 1'b0;
  logic        In_Ready;
  logic [31:0] PCIn = '0;
  logic [31:0] RegBase = '0;
  logic [31:0] OpA = '0;
  logic [31:0] OpB = '0;
  logic [15:0] Offset = '0;
  logic [2:0]  Mode = '0;
  logic        Out_Valid;
  logic        Out_Ready = 1'b1;
  logic [31:0] Target;
  logic [31:0] NextPC;
  logic        Taken;
  logic        Misalign;

  branch_target_unit dut (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .PCIn(PCIn), .RegBase(RegBase), .OpA(OpA), .OpB(OpB),
    .Offset(Offset), .Mode(Mode),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Target(Target), .NextPC(NextPC),
    .Taken(Taken), .Misalign(Misalign)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] t;
    logic [31:0] n;
    logic        tk;
    logic        m;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   rnd_on = 1'b0;
  logic hold = 1'b0;
  exp_t saved;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: signed offset scaled by 4, base chosen by mode.
  function automatic exp_t model(input logic [31:0] pc, rb, a, b,
                                 input logic [15:0] off,
                                 input logic [2:0] m);
    exp_t e;
    int so;
    logic [31:0] base;
    so = int'($signed(off));
    base = (m == 3'd5) ? rb : pc;
    e.t = base + 32'(so * 4);
    case (m)
      3'd0: e.tk = (a == b);
      3'd1: e.tk = (a != b);
      3'd2: e.tk = ($signed(a) < $signed(b));
      3'd3: e.tk = ($signed(a) >= $signed(b));
      3'd4, 3'd5: e.tk = 1'b1;
      default: e.tk = 1'b0;
    endcase
    e.n = e.tk ? e.t : pc + 32'd4;
    e.m = e.tk && (e.t[1:0] != 2'b00);
    return e;
  endfunction

  always @(negedge Clk) begin
    exp_t e;
    if (!Rst_n) begin
      q.delete();
      hold <= 1'b0;
    end else begin
      chk("in_ready", {31'd0, In_Ready},
          {31'd0, Flush || !(q.size() == 2 && !Out_Ready)});
      chk("valid_no_pending", {31'd0, Out_Valid && q.size() == 0}, 32'd0);
      if (hold) begin
        chk("hold_valid", {31'd0, Out_Valid}, 32'd1);
        chk("hold_target", Target, saved.t);
        chk("hold_nextpc", NextPC, saved.n);
        chk("hold_flags", {30'd0, Taken, Misalign},
            {30'd0, saved.tk, saved.m});
      end
      if (Flush) begin
        q.delete();
        hold <= 1'b0;
      end else begin
        hold <= Out_Valid && !Out_Ready;
        saved <= '{t: Target, n: NextPC, tk: Taken, m: Misalign};
        if (Out_Valid && Out_Ready && q.size() > 0) begin
          e = q.pop_front();
          chk("target", Target, e.t);
          chk("nextpc", NextPC, e.n);
          chk("taken", {31'd0, Taken}, {31'd0, e.tk});
          chk("misalign", {31'd0, Misalign}, {31'd0, e.m});
        end
        if (In_Valid && In_Ready)
          q.push_back(model(PCIn, RegBase, OpA, OpB, Offset, Mode));
      end
    end
  end

  always @(posedge Clk) begin
    if (rnd_on) begin
      #1;
      Out_Ready = ($urandom_range(0, 3) != 0);
      Flush = ($urandom_range(0, 31) == 0);
    end
  end

  task automatic issue(input logic [31:0] pc, rb, a, b,
                       input logic [15:0] off, input logic [2:0] m);
    bit ok;
    PCIn = pc; RegBase = rb; OpA = a; OpB = b;
    Offset = off; Mode = m; In_Valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge Clk);
      if (In_Ready && !Flush) ok = 1'b1;
      @(posedge Clk); #1;
    end
    In_Valid = 1'b0;
    if (!rnd_on) chk("accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || Out_Valid) && n < 60) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_valid", {31'd0, Out_Valid}, 32'd0);
    chk("rst_target", Target, 32'd0);
    chk("rst_nextpc", NextPC, 32'd0);
    chk("rst_flags", {30'd0, Taken, Misalign}, 32'd0);
    Rst_n = 1'b1;
    #1 chk("rst_inready", {31'd0, In_Ready}, 32'd1);
    @(posedge Clk); #1;

    // BEQ taken forward, with latency check
    issue(32'h100, 32'h0, 32'd5, 32'd5, 16'h0010, 3'd0);
    chk("lat_early", {31'd0, Out_Valid}, 32'd0);
    @(posedge Clk); #1;
    chk("lat_valid", {31'd0, Out_Valid}, 32'd1);
    chk("beq_target", Target, 32'h140);
    chk("beq_nextpc", NextPC, 32'h140);
    chk("beq_flags", {30'd0, Taken, Misalign}, 32'h2);
    drain();

    // BLT backward, not taken
    issue(32'h200, 32'h0, 32'd3, 32'hFFFF_FFFF, 16'hFFFF, 3'd2);
    @(posedge Clk); #1;
    chk("blt_target", Target, 32'h1FC);
    chk("blt_nextpc", NextPC, 32'h204);
    chk("blt_flags", {30'd0, Taken, Misalign}, 32'h0);
    drain();

    // JR misaligned and wrapping
    issue(32'h400, 32'hFFFF_FFFE, 32'd0, 32'd0, 16'h0001, 3'd5);
    @(posedge Clk); #1;
    chk("jr_target", Target, 32'h0000_0002);
    chk("jr_flags", {30'd0, Taken, Misalign}, 32'h3);
    drain();

    // Backpressure: two accepts fill the pipe, third stalls
    Out_Ready = 1'b0;
    issue(32'h1000, 32'h0, 32'd1, 32'd2, 16'h0004, 3'd1);
    issue(32'h2000, 32'h0, 32'd1, 32'd1, 16'h0008, 3'd1);
    PCIn = 32'h3000; Offset = 16'hFFF0; Mode = 3'd4; In_Valid = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      chk("bp_inready", {31'd0, In_Ready}, 32'd0);
    end
    @(posedge Clk); #1;
    Out_Ready = 1'b1;
    issue(32'h3000, 32'h0, 32'd0, 32'd0, 16'hFFF0, 3'd4);
    issue(32'h4000, 32'h0, 32'hFFFF_FFF0, 32'd7, 16'h0002, 3'd3);
    drain();

    // Flush with both stages full and a request presented
    Out_Ready = 1'b0;
    issue(32'h5000, 32'h0, 32'd9, 32'd9, 16'h0001, 3'd0);
    issue(32'h6000, 32'h0, 32'd9, 32'd9, 16'h0002, 3'd0);
    PCIn = 32'h7000; Offset = 16'h0003; Mode = 3'd4;
    In_Valid = 1'b1; Flush = 1'b1;
    @(negedge Clk);
    chk("flush_inready", {31'd0, In_Ready}, 32'd1);
    @(posedge Clk); #1;
    Flush = 1'b0; In_Valid = 1'b0;
    chk("flush_valid", {31'd0, Out_Valid}, 32'd0);
    @(posedge Clk); #1;
    chk("flush_dropped", {31'd0, Out_Valid}, 32'd0);
    Out_Ready = 1'b1;
    issue(32'h8000, 32'h0, 32'd0, 32'd0, 16'h0010, 3'd4);
    @(posedge Clk); #1;
    chk("post_flush_valid", {31'd0, Out_Valid}, 32'd1);
    chk("post_flush_target", Target, 32'h8040);
    drain();

    // Asynchronous reset while a result is waiting
    Out_Ready = 1'b0;
    issue(32'h300, 32'h0, 32'd1, 32'd1, 16'h0008, 3'd0);
    @(posedge Clk); #1;
    chk("pre_rst_valid", {31'd0, Out_Valid}, 32'd1);
    #2 Rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, Out_Valid}, 32'd0);
    chk("async_target", Target, 32'd0);
    chk("async_nextpc", NextPC, 32'd0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    Out_Ready = 1'b1;
    #1 chk("rel_inready", {31'd0, In_Ready}, 32'd1);
    repeat (3) @(posedge Clk);
    #1 chk("rel_no_output", {31'd0, Out_Valid}, 32'd0);

    // Randomized traffic
    rnd_on = 1'b1;
    for (int k = 0; k < 200; k++) begin
      logic [31:0] a, b, rb, pc;
      a  = $urandom();
      b  = ($urandom_range(0, 2) == 0) ? a : $urandom();
      if ($urandom_range(0, 4) == 0) b = a + 32'($urandom_range(0, 2)) - 32'd1;
      rb = $urandom();
      pc = $urandom() & 32'hFFFF_FFFC;
      issue(pc, rb, a, b, 16'($urandom()), 3'($urandom_range(0, 7)));
    end
    rnd_on = 1'b0;
    @(posedge Clk); #2;
    Flush = 1'b0;
    Out_Ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
